// File: rtl/drv_audio_i2s_codec.sv
// drv_audio_i2s_codec: I2S master for WM8731-class codecs
// Generates XCK/BCLK/LRCK from i_clk, serialises double-buffered stereo DAC samples
// taken over a valid/ready handshake, and optionally deserialises stereo ADC samples.
// Ports: i_clk/i_rst (sync, active-low); o_drv_xck, o_drv_bclk, o_drv_dac_lrck,
//   o_drv_dac_dat, o_drv_adc_lrck, i_drv_adc_dat (codec pins); i_smp_l/i_smp_r/
//   i_smp_val/o_smp_rdy (DAC sample handshake); o_frame, o_underrun (status pulses);
//   o_adc_l/o_adc_r/o_adc_val (captured ADC pair).
// Build option: define DRV_AUDIO_ADC_EN to include the ADC capture path.
module drv_audio_i2s_codec #(
    parameter int p_width    = 16,
    parameter int p_slot     = 32,
    parameter int p_bclk_div = 8,
    parameter int p_xck_div  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic               o_drv_xck,
    output logic               o_drv_bclk,
    output logic               o_drv_dac_lrck,
    output logic               o_drv_dac_dat,
    output logic               o_drv_adc_lrck,
    input  logic               i_drv_adc_dat,
    input  logic [p_width-1:0] i_smp_l,
    input  logic [p_width-1:0] i_smp_r,
    input  logic               i_smp_val,
    output logic               o_smp_rdy,
    output logic               o_frame,
    output logic               o_underrun,
    output logic [p_width-1:0] o_adc_l,
    output logic [p_width-1:0] o_adc_r,
    output logic               o_adc_val
);
    localparam int CW = $clog2(2 * p_slot);
    localparam int BW = $clog2(p_bclk_div + 1);
    localparam int XW = $clog2(p_xck_div + 1);
    localparam logic [CW-1:0] LAST = CW'(2 * p_slot - 1);
    localparam logic [CW-1:0] SLOT = CW'(p_slot);
    localparam logic [CW-1:0] WID  = CW'(p_width);
    localparam logic [BW-1:0] BLAST = BW'(p_bclk_div - 1);
    localparam logic [XW-1:0] XLAST = XW'(p_xck_div - 1);

    logic [BW-1:0]          bdiv;
    logic [XW-1:0]          xdiv;
    logic [CW-1:0]          bit_cnt, nxt, nj;
    logic                   tick, fall, fs, xfer, nbit, hold_full;
    logic [2*p_width-1:0]   shift, hold;

    always_comb begin
        tick           = bdiv == BLAST;
        fall           = tick & o_drv_bclk;
        fs             = fall && bit_cnt == LAST;
        nxt            = bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
        nj             = nxt >= SLOT ? nxt - SLOT : nxt;
        nbit           = nj != '0 && nj <= WID;
        xfer           = i_smp_val & ~hold_full;
        o_smp_rdy      = ~hold_full;
        o_drv_adc_lrck = o_drv_dac_lrck;
    end

    // The shift register holds {L,R}; each data slot bit pops the MSB, so the left
    // slot drains L and the right slot drains R. nbit is evaluated for the slot
    // position the fall is moving into, which gives the one-BCLK I2S delay.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            xdiv           <= '0;
            bdiv           <= '0;
            o_drv_xck      <= 1'b0;
            o_drv_bclk     <= 1'b1;
            o_drv_dac_lrck <= 1'b1;
            o_drv_dac_dat  <= 1'b0;
            o_frame        <= 1'b0;
            o_underrun     <= 1'b0;
            bit_cnt        <= LAST;
            hold_full      <= 1'b0;
            hold           <= '0;
            shift          <= '0;
        end else begin
            xdiv       <= xdiv == XLAST ? '0 : xdiv + 1'b1;
            o_drv_xck  <= xdiv == XLAST ? ~o_drv_xck : o_drv_xck;
            bdiv       <= tick ? '0 : bdiv + 1'b1;
            o_drv_bclk <= tick ? ~o_drv_bclk : o_drv_bclk;
            o_frame    <= fs;
            o_underrun <= fs & ~hold_full;
            hold_full  <= xfer | (hold_full & ~fs);
            if (xfer) hold <= {i_smp_l, i_smp_r};
            if (fall) begin
                bit_cnt        <= nxt;
                o_drv_dac_lrck <= nxt >= SLOT;
                o_drv_dac_dat  <= nbit & shift[2*p_width-1];
                shift          <= fs ? (hold_full ? hold : '0) : nbit ? {shift[2*p_width-2:0], 1'b0} : shift;
            end
        end
    end

`ifdef DRV_AUDIO_ADC_EN
    logic [p_width-1:0] sh_l, sh_r;
    logic [CW-1:0]      cj;
    logic               rise, cbit;

    always_comb begin
        rise = tick & ~o_drv_bclk;
        cj   = bit_cnt >= SLOT ? bit_cnt - SLOT : bit_cnt;
        cbit = rise && cj != '0 && cj <= WID;
    end

    // Shifting in MSB first leaves the sample bit-aligned once all p_width slot
    // bits of the channel have been taken.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sh_l      <= '0;
            sh_r      <= '0;
            o_adc_l   <= '0;
            o_adc_r   <= '0;
            o_adc_val <= 1'b0;
        end else begin
            if (cbit && bit_cnt >= SLOT) sh_r <= {sh_r[p_width-2:0], i_drv_adc_dat};
            if (cbit && bit_cnt < SLOT) sh_l <= {sh_l[p_width-2:0], i_drv_adc_dat};
            o_adc_val <= fs;
            if (fs) begin
                o_adc_l <= sh_l;
                o_adc_r <= sh_r;
            end
        end
    end
`else
    logic unused_adc;

    always_comb begin
        unused_adc = i_drv_adc_dat;
        o_adc_l    = '0;
        o_adc_r    = '0;
        o_adc_val  = 1'b0;
    end
`endif
endmodule

// File: tb/tb_drv_audio_i2s_codec.sv
// tb_drv_audio_i2s_codec: directed self-checking bench for drv_audio_i2s_codec
module tb_drv_audio_i2s_codec;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        xck, bclk, dlr, dat, alr, rdy, frame, und, aval, val;
    logic [15:0] sl, sr, adc_l, adc_r;
    logic [63:0] d, w;
    int          compared = 0;
    int          mismatched = 0;

    localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

    drv_audio_i2s_codec dut (
        .i_clk(clk), .i_rst(rst), .o_drv_xck(xck), .o_drv_bclk(bclk),
        .o_drv_dac_lrck(dlr), .o_drv_dac_dat(dat), .o_drv_adc_lrck(alr),
        .i_drv_adc_dat(dat), .i_smp_l(sl), .i_smp_r(sr), .i_smp_val(val),
        .o_smp_rdy(rdy), .o_frame(frame), .o_underrun(und),
        .o_adc_l(adc_l), .o_adc_r(adc_r), .o_adc_val(aval)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] e;
        e = '0;
        for (int j = 1; j <= 16; j++) begin
            e[j]      = l[16-j];
            e[j + 32] = r[16-j];
        end
        return e;
    endfunction

    // Entered on the cycle o_frame is seen; records data/LRCK after each of the
    // 64 BCLK falls of the frame, optionally offering one sample pair on entry.
    task automatic capture(input logic send, input logic [15:0] l, input logic [15:0] r,
                           output logic [63:0] bits, output logic [63:0] lr);
        bits[0] = dat;
        lr[0]   = dlr;
        if (send) begin
            sl  = l;
            sr  = r;
            val = 1'b1;
        end
        @(negedge clk);
        val = 1'b0;
        repeat (15) @(negedge clk);
        for (int k = 1; k < 64; k++) begin
            bits[k] = dat;
            lr[k]   = dlr;
            if (k < 63) repeat (16) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [7:0] xs, bs;
        val = 1'b0; sl = '0; sr = '0; rst = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({xck, bclk, dlr, alr, dat, rdy, frame, und, aval} !== 9'b011101000)
            $display("FAIL reset_out: got %b want 011101000", {xck, bclk, dlr, alr, dat, rdy, frame, und, aval});
        compared++;
        if ({adc_l, adc_r} !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_adc: got %h want 00000000", {adc_l, adc_r});
        end
        if ({xck, bclk, dlr, alr, dat, rdy, frame, und, aval} !== 9'b011101000) mismatched++;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            xs[i] = xck;
            bs[i] = bclk;
        end
        compared++;
        if (xs !== 8'h66) begin
            mismatched++;
            $display("FAIL xck_pattern: got %h want 66", xs);
        end
        compared++;
        if (bs !== 8'h7F) begin
            mismatched++;
            $display("FAIL bclk_first_fall: got %h want 7f", bs);
        end
        compared++;
        if ({frame, und, dlr} !== 3'b110) begin
            mismatched++;
            $display("FAIL first_frame_start: got %b want 110", {frame, und, dlr});
        end
    endtask

    task automatic test_first_frame;
        capture(1'b1, 16'hA5C3, 16'h0001, d, w);
        compared++;
        if (d !== 64'h0) begin
            mismatched++;
            $display("FAIL first_frame_mute: got %h want 0", d);
        end
        compared++;
        if (w !== LR_EXP) begin
            mismatched++;
            $display("FAIL lrck_pattern: got %h want %h", w, LR_EXP);
        end
        repeat (16) @(negedge clk);
        compared++;
        if ({frame, und, rdy} !== 3'b101) begin
            mismatched++;
            $display("FAIL second_frame_start: got %b want 101", {frame, und, rdy});
        end
        capture(1'b0, 16'h0, 16'h0, d, w);
        compared++;
        if (d !== exp_frame(16'hA5C3, 16'h0001)) begin
            mismatched++;
            $display("FAIL play_a5c3_0001: got %h want %h", d, exp_frame(16'hA5C3, 16'h0001));
        end
    endtask

    task automatic test_stream;
        int xfers = 0, unds = 0, frames = 0, lows = 0;
        sl = 16'h1111; sr = 16'h2222; val = 1'b1;
        @(negedge clk);
        compared++;
        if (rdy !== 1'b0) begin
            mismatched++;
            $display("FAIL stream_first_rdy: got %b want 0", rdy);
        end
        repeat (15) @(negedge clk);
        for (int i = 0; i < 3072; i++) begin
            if (rdy === 1'b1) xfers++;
            if (rdy === 1'b0) lows++;
            if (und === 1'b1) unds++;
            if (frame === 1'b1) frames++;
            @(negedge clk);
        end
        val = 1'b0;
        compared++;
        if (xfers != 3 || frames != 3) begin
            mismatched++;
            $display("FAIL stream_xfers: got %0d xfers %0d frames want 3 3", xfers, frames);
        end
        compared++;
        if (lows != 3069) begin
            mismatched++;
            $display("FAIL stream_rdy_low: got %0d want 3069", lows);
        end
        compared++;
        if (unds != 0 || {frame, und} !== 2'b10) begin
            mismatched++;
            $display("FAIL stream_underrun: got %0d pulses end %b want 0 10", unds, {frame, und});
        end
        capture(1'b0, 16'h0, 16'h0, d, w);
        compared++;
        if (d !== exp_frame(16'h1111, 16'h2222)) begin
            mismatched++;
            $display("FAIL stream_play: got %h want %h", d, exp_frame(16'h1111, 16'h2222));
        end
    endtask

    task automatic test_same_cycle;
        repeat (15) @(negedge clk);
        sl = 16'h1234; sr = 16'hABCD; val = 1'b1;
        @(negedge clk);
        val = 1'b0;
        compared++;
        if ({frame, und, rdy} !== 3'b110) begin
            mismatched++;
            $display("FAIL same_cycle_start: got %b want 110", {frame, und, rdy});
        end
        capture(1'b0, 16'h0, 16'h0, d, w);
        compared++;
        if (d !== 64'h0) begin
            mismatched++;
            $display("FAIL same_cycle_mute: got %h want 0", d);
        end
        repeat (16) @(negedge clk);
        compared++;
        if ({frame, und} !== 2'b10) begin
            mismatched++;
            $display("FAIL same_cycle_next: got %b want 10", {frame, und});
        end
        capture(1'b0, 16'h0, 16'h0, d, w);
        compared++;
        if (d !== exp_frame(16'h1234, 16'hABCD)) begin
            mismatched++;
            $display("FAIL same_cycle_play: got %h want %h", d, exp_frame(16'h1234, 16'hABCD));
        end
    endtask

    task automatic test_reset_mid;
        repeat (16) @(negedge clk);
        sl = 16'h5A5A; sr = 16'hC3C3; val = 1'b1;
        @(negedge clk);
        val = 1'b0;
        compared++;
        if (rdy !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_hold_full: got %b want 0", rdy);
        end
        repeat (319) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({xck, bclk, dlr, alr, dat, rdy, frame, und, aval, adc_l, adc_r} !== {9'b011101000, 32'h0}) begin
            mismatched++;
            $display("FAIL mid_reset_out: got %h want %h", {xck, bclk, dlr, alr, dat, rdy, frame, und, aval, adc_l, adc_r},
                     {9'b011101000, 32'h0});
        end
        rst = 1'b1;
        repeat (7) @(negedge clk);
        compared++;
        if (bclk !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_bclk_hold: got %b want 1", bclk);
        end
        @(negedge clk);
        compared++;
        if ({bclk, frame, und, rdy} !== 4'b0111) begin
            mismatched++;
            $display("FAIL mid_release_start: got %b want 0111", {bclk, frame, und, rdy});
        end
        capture(1'b0, 16'h0, 16'h0, d, w);
        compared++;
        if (d !== 64'h0) begin
            mismatched++;
            $display("FAIL mid_discard: got %h want 0", d);
        end
    endtask

    task automatic test_adc;
        logic [32:0] want;
`ifdef DRV_AUDIO_ADC_EN
        want = {1'b1, 16'h8001, 16'h7FFE};
`else
        want = 33'h0;
`endif
        repeat (16) @(negedge clk);
        capture(1'b1, 16'h8001, 16'h7FFE, d, w);
        repeat (16) @(negedge clk);
        compared++;
        if ({frame, und} !== 2'b10) begin
            mismatched++;
            $display("FAIL adc_play_start: got %b want 10", {frame, und});
        end
        capture(1'b0, 16'h0, 16'h0, d, w);
        compared++;
        if (d !== exp_frame(16'h8001, 16'h7FFE)) begin
            mismatched++;
            $display("FAIL adc_play: got %h want %h", d, exp_frame(16'h8001, 16'h7FFE));
        end
        repeat (16) @(negedge clk);
        compared++;
        if ({aval, adc_l, adc_r} !== want) begin
            mismatched++;
            $display("FAIL adc_capture: got %h want %h", {aval, adc_l, adc_r}, want);
        end
        @(negedge clk);
        compared++;
        if (aval !== 1'b0) begin
            mismatched++;
            $display("FAIL adc_val_width: got %b want 0", aval);
        end
    endtask

    initial begin
        test_reset;
        test_first_frame;
        test_stream;
        test_same_cycle;
        test_reset_mid;
        test_adc;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
